// File: rtl/recon_sum_pkg.sv
// Shared definitions for the 4x4 reconstruction block: FSM states, plane codes,
// buffer base addresses and the reconstruction-buffer address map.
package recon_sum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] KIND_LUMA = 2'd0;
   localparam logic [1:0] KIND_CB   = 2'd1;
   localparam logic [1:0] KIND_CR   = 2'd2;
   localparam logic [1:0] KIND_RSVD = 2'd3;

   localparam logic [6:0] CB_BASE = 7'd64;
   localparam logic [6:0] CR_BASE = 7'd80;

   localparam int PIX_MAX = 255;

   // Luma blocks tile an 4x4 grid of 4-word rows; chroma blocks a 2x2 grid of 2-word rows.
   function automatic logic [6:0] rec_addr(input logic [1:0] kind,
                                           input logic [3:0] idx,
                                           input logic [1:0] row);
      case (kind)
         KIND_CB: rec_addr = CB_BASE + {3'b000, idx[1], row, idx[0]};
         KIND_CR: rec_addr = CR_BASE + {3'b000, idx[1], row, idx[0]};
         default: rec_addr = {1'b0, idx[3], idx[1], row, idx[2], idx[0]};
      endcase
   endfunction

endpackage

// File: rtl/recon_clip8.sv
// One reconstructed pixel: unsigned prediction plus signed residual, clipped to 0..255.
module recon_clip8
   import recon_sum_pkg::*;
#(
   parameter int RES_W = 10
) (
   input  logic [7:0]              i_pred,
   input  logic signed [RES_W-1:0] i_res,
   output logic [7:0]              o_pix
);

   localparam logic signed [RES_W+1:0] SUM_MAX = (RES_W+2)'(PIX_MAX);

   function automatic logic [7:0] clip_u8(input logic signed [RES_W+1:0] v);
      if (v[RES_W+1]) return 8'd0;
      if (v > SUM_MAX) return 8'hFF;
      return v[7:0];
   endfunction

   logic signed [RES_W+1:0] w_sum;

   assign w_sum = $signed({{(RES_W-6){1'b0}}, i_pred}) + $signed({{2{i_res[RES_W-1]}}, i_res});
   assign o_pix = clip_u8(w_sum);

endmodule

// File: rtl/recon_sum.sv
// 4x4 block reconstruction: reads prediction rows, adds the captured residual,
// clips and writes reconstructed rows; the whole pipeline stalls on ena low.
module recon_sum
   import recon_sum_pkg::*;
#(
   parameter int RES_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  start,
   input  logic                  residual_all_0,
   input  logic [1:0]            blk_kind,
   input  logic [3:0]            blk_idx,
   input  logic [16*RES_W-1:0]   res_in,
   output logic                  pred_rd_en,
   output logic [1:0]            pred_rd_row,
   input  logic [31:0]           pred_rd_data,
   output logic                  rec_wr_en,
   output logic [6:0]            rec_wr_addr,
   output logic [31:0]           rec_wr_data,
   output logic                  busy,
   output logic                  done
);

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_rd_row;
   logic                r_rd_pend;
   logic [31:0]         r_pred;
   logic [16*RES_W-1:0] r_res;
   logic                r_all0;
   logic [1:0]          r_kind;
   logic [3:0]          r_idx;
   logic                r_wr_pend_p1;
   logic [1:0]          r_wr_row_p1;
   logic                r_wr_en_p2;
   logic                r_last_p2;
   logic [6:0]          r_addr_p2;
   logic [31:0]         r_data_p2;
   logic                w_accept;
   logic [31:0]         w_pred;
   logic [31:0]         w_pix;
   logic signed [RES_W-1:0] w_res [4];

   assign w_accept = ena && (r_state == ST_IDLE) && start;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else if (ena)
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = ST_READ;
         ST_READ:  if (r_rd_row == 2'd3) w_next = ST_DRAIN;
         ST_DRAIN: if (r_wr_en_p2 && r_last_p2) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      pred_rd_en = ena && (r_state == ST_READ);
      busy       = (r_state != ST_IDLE);
      done       = ena && (r_state == ST_DONE);
   end

   assign pred_rd_row = r_rd_row;
   assign rec_wr_en   = ena && r_wr_en_p2;
   assign rec_wr_addr = r_addr_p2;
   assign rec_wr_data = r_data_p2;

   // A stalled write stage may see its row after the bus has moved on, so use the held copy.
   assign w_pred = r_rd_pend ? pred_rd_data : r_pred;

   for (genvar c = 0; c < 4; c++) begin : g_byte
      assign w_res[c] = r_all0 ? '0 : r_res[(int'(r_wr_row_p1) * 4 + c) * RES_W +: RES_W];
      recon_clip8 #(.RES_W(RES_W)) u_clip (
         .i_pred (w_pred[c*8 +: 8]),
         .i_res  (w_res[c]),
         .o_pix  (w_pix[c*8 +: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_row     <= '0;
         r_rd_pend    <= 1'b0;
         r_pred       <= '0;
         r_res        <= '0;
         r_all0       <= 1'b0;
         r_kind       <= '0;
         r_idx        <= '0;
         r_wr_pend_p1 <= 1'b0;
         r_wr_row_p1  <= '0;
         r_wr_en_p2   <= 1'b0;
         r_last_p2    <= 1'b0;
         r_addr_p2    <= '0;
         r_data_p2    <= '0;
      end else begin
         r_rd_pend <= pred_rd_en;
         if (r_rd_pend)
            r_pred <= pred_rd_data;
         if (w_accept) begin
            r_res  <= res_in;
            r_all0 <= residual_all_0;
            r_kind <= blk_kind;
            r_idx  <= blk_idx;
         end
         // stage p1: row read issued, awaiting its prediction word
         if (ena) begin
            if (pred_rd_en) begin
               r_rd_row    <= r_rd_row + 2'd1;
               r_wr_row_p1 <= r_rd_row;
            end
            r_wr_pend_p1 <= pred_rd_en;
            // stage p2: registered write word
            r_wr_en_p2 <= r_wr_pend_p1;
            if (r_wr_pend_p1) begin
               r_addr_p2 <= rec_addr(r_kind, r_idx, r_wr_row_p1);
               r_data_p2 <= w_pix;
               r_last_p2 <= (r_wr_row_p1 == 2'd3);
            end
         end
      end
   end

endmodule
